// File: rtl/mat_iscan.sv
// mat_iscan: inverse zigzag scan for 8x8 blocks.
// Takes 64 samples in JPEG zigzag order and replays them in raster order.
// Two 64-entry banks are used as a ping-pong pair. One block fills the write
// bank while the previously completed block is read out of the other bank.
module mat_iscan #(
  parameter int DW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vld_in,
  input  logic [DW-1:0] din,
  output logic          vld_out,
  output logic [DW-1:0] dout
);

  typedef enum logic {IDLE, READ} state_t;

  // Both banks live in one array. The MSB of the address selects the bank.
  logic [DW-1:0] mem [0:127];

  logic [5:0] wcnt_reg;
  logic [5:0] rcnt_reg;
  logic       wbank_reg;
  logic       rbank_reg;
  state_t     state_reg;
  state_t     state_next;
  logic       launch;

  // The final zigzag sample of a block is being accepted on this edge.
  assign launch = vld_in && (wcnt_reg == 6'd63);

  // Zigzag index -> raster address (standard JPEG scan order).
  function automatic logic [5:0] zz2r(input logic [5:0] k);
    logic [5:0] r;
    case (k)
      6'd0:  r = 6'd0;  6'd1:  r = 6'd1;  6'd2:  r = 6'd8;  6'd3:  r = 6'd16;
      6'd4:  r = 6'd9;  6'd5:  r = 6'd2;  6'd6:  r = 6'd3;  6'd7:  r = 6'd10;
      6'd8:  r = 6'd17; 6'd9:  r = 6'd24; 6'd10: r = 6'd32; 6'd11: r = 6'd25;
      6'd12: r = 6'd18; 6'd13: r = 6'd11; 6'd14: r = 6'd4;  6'd15: r = 6'd5;
      6'd16: r = 6'd12; 6'd17: r = 6'd19; 6'd18: r = 6'd26; 6'd19: r = 6'd33;
      6'd20: r = 6'd40; 6'd21: r = 6'd48; 6'd22: r = 6'd41; 6'd23: r = 6'd34;
      6'd24: r = 6'd27; 6'd25: r = 6'd20; 6'd26: r = 6'd13; 6'd27: r = 6'd6;
      6'd28: r = 6'd7;  6'd29: r = 6'd14; 6'd30: r = 6'd21; 6'd31: r = 6'd28;
      6'd32: r = 6'd35; 6'd33: r = 6'd42; 6'd34: r = 6'd49; 6'd35: r = 6'd56;
      6'd36: r = 6'd57; 6'd37: r = 6'd50; 6'd38: r = 6'd43; 6'd39: r = 6'd36;
      6'd40: r = 6'd29; 6'd41: r = 6'd22; 6'd42: r = 6'd15; 6'd43: r = 6'd23;
      6'd44: r = 6'd30; 6'd45: r = 6'd37; 6'd46: r = 6'd44; 6'd47: r = 6'd51;
      6'd48: r = 6'd58; 6'd49: r = 6'd59; 6'd50: r = 6'd52; 6'd51: r = 6'd45;
      6'd52: r = 6'd38; 6'd53: r = 6'd31; 6'd54: r = 6'd39; 6'd55: r = 6'd46;
      6'd56: r = 6'd53; 6'd57: r = 6'd60; 6'd58: r = 6'd61; 6'd59: r = 6'd54;
      6'd60: r = 6'd47; 6'd61: r = 6'd55; 6'd62: r = 6'd62; 6'd63: r = 6'd63;
      default: r = 6'd0;
    endcase
    return r;
  endfunction

  // Write port: scatter each zigzag sample to its raster slot in the write bank.
  always_ff @(posedge clk) begin
    if (vld_in) begin
      mem[{wbank_reg, zz2r(wcnt_reg)}] <= din;
    end
  end

  // Write counter and bank select.
  // A completed block flips the banks and records which bank to read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_reg  <= 6'd0;
      wbank_reg <= 1'b0;
      rbank_reg <= 1'b0;
    end else if (vld_in) begin
      wcnt_reg <= wcnt_reg + 6'd1;
      if (launch) begin
        wbank_reg <= ~wbank_reg;
        rbank_reg <= wbank_reg;
      end
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Read FSM next state.
  // A launch on the final read edge chains straight into the next block.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (launch) state_next = READ;
      READ: if (rcnt_reg == 6'd63) state_next = launch ? READ : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Read counter. It wraps 63 -> 0 on its own, which also covers back-to-back blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt_reg <= 6'd0;
    end else if (state_reg == READ) begin
      rcnt_reg <= rcnt_reg + 6'd1;
    end else begin
      rcnt_reg <= 6'd0;
    end
  end

  // Registered read port.
  // dout keeps its last value while no block is being read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_out <= 1'b0;
      dout    <= '0;
    end else begin
      vld_out <= (state_reg == READ);
      if (state_reg == READ) begin
        dout <= mem[{rbank_reg, rcnt_reg}];
      end
    end
  end

endmodule

// File: tb/tb_mat_iscan.sv
// tb_mat_iscan: scoreboard bench for the inverse zigzag scanner.
// The stimulus pushes the expected raster sample and its output cycle.
// A negedge monitor checks every cycle for the expected value or for silence.
module tb_mat_iscan;

  logic       clk;
  logic       rst_n;
  logic       vld_in;
  logic [9:0] din;
  logic       vld_out;
  logic [9:0] dout;

  mat_iscan #(.DW(10)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .vld_in  (vld_in),
    .din     (din),
    .vld_out (vld_out),
    .dout    (dout)
  );

  typedef struct {
    logic [9:0] d;
    int         c;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_err  = 0;
  int   cyc    = 0;
  int   kk     = 0;
  int   last_e = 0;
  logic [9:0] vals [64];
  int   zz_of  [64];

  // Raster r -> zigzag k, transcribed from the JPEG table.
  int R2ZZ [64] = '{0, 1, 5, 6, 14, 15, 27, 28,
                    2, 4, 7, 13, 16, 26, 29, 42,
                    3, 8, 12, 17, 25, 30, 41, 43,
                    9, 11, 18, 24, 31, 40, 44, 53,
                    10, 19, 23, 32, 39, 45, 52, 54,
                    20, 22, 33, 38, 46, 51, 55, 60,
                    21, 34, 37, 47, 50, 56, 59, 61,
                    35, 36, 48, 49, 57, 58, 62, 63};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count active clock edges.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: either the head of the queue is due this cycle, or the output must be idle.
  always @(negedge clk) begin
    if (rst_n) begin
      while (q.size() > 0 && q[0].c < cyc) void'(q.pop_front());
      if (q.size() > 0 && q[0].c == cyc) begin
        exp_t e;
        e = q.pop_front();
        check("vld_out_due", {31'd0, vld_out}, 32'd1);
        check("dout", {22'd0, dout}, {22'd0, e.d});
        $display("out cyc=%0d dout=%0d exp=%0d", cyc, dout, e.d);
      end else begin
        check("vld_out_idle", {31'd0, vld_out}, 32'd0);
      end
    end
  end

  // Drive one zigzag sample. When a block completes, queue its raster-order output.
  task automatic send(input logic [9:0] d);
    @(negedge clk);
    vld_in = 1'b1;
    din    = d;
    @(posedge clk);
    #1;
    vals[kk] = d;
    if (kk == 63) begin
      for (int r = 0; r < 64; r++) begin
        q.push_back('{vals[R2ZZ[r]], cyc + r + 1});
      end
      last_e = cyc;
    end
    kk = (kk + 1) % 64;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    vld_in = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() > 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    check("drain_queue_empty", q.size(), 32'd0);
    idle(3);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    vld_in = 1'b0;
    q.delete();
    kk = 0;
    #1;
    check("rst_vld_out", {31'd0, vld_out}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int r = 0; r < 64; r++) zz_of[R2ZZ[r]] = r;
    rst_n  = 1'b1;
    vld_in = 1'b0;
    din    = '0;
    #3;
    rst_n = 1'b0;
    #1;
    check("reset_vld_out", {31'd0, vld_out}, 32'd0);
    check("reset_dout", {22'd0, dout}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single block, din = zigzag index.
    for (int k = 0; k < 64; k++) send(10'(k));
    idle(2);
    drain();

    // 2: three back-to-back blocks.
    for (int b = 0; b < 3; b++)
      for (int k = 0; k < 64; k++) send(10'(b * 64 + k));
    idle(2);
    drain();

    // 3: two 5-cycle input gaps inside one block.
    for (int k = 0; k < 64; k++) begin
      send(10'(k));
      if (k == 9 || k == 39) idle(5);
    end
    idle(2);
    drain();

    // 4: reset after 30 beats, then a full block offset by 100.
    for (int k = 0; k < 30; k++) send(10'(500 + k));
    pulse_reset();
    for (int k = 0; k < 64; k++) send(10'(100 + k));
    idle(2);
    drain();

    // 5: reset during output beat 20.
    for (int k = 0; k < 64; k++) send(10'(300 + k));
    idle(1);
    while (cyc < last_e + 21) @(posedge clk);
    #2;
    rst_n = 1'b0;
    q.delete();
    kk = 0;
    #1;
    check("midread_rst_vld_out", {31'd0, vld_out}, 32'd0);
    check("midread_rst_dout", {22'd0, dout}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(80);

    // 6: loopback, where a zigzag-ordered raster ramp should come back as 0..63.
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 64; k++) send(10'(zz_of[k]));
    idle(2);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
